signed_mac_accum: RTL and testbench

- Sequential accumulator directly downstream of signed_array_mplier.
- Consumes the 2N-bit signed product over a valid/ready handshake and sums a programmed number of terms into a wide signed accumulator, with saturation.
- Presents the final sum on a valid/ready output port.
- Forms the accumulate half of the team's MAC / dot-product datapath.

---
 rtl/signed_mac_accum_if.sv | 27 ++
 rtl/signed_mac_accum.sv | 79 +++++++
 tb/tb_signed_mac_accum.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/signed_mac_accum_if.sv
// rtl/signed_mac_accum_if.sv - job, product-stream and result handshake bundle for signed_mac_accum
interface signed_mac_accum_if #(
    parameter int N     = 32,
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
);
    logic                    start;
    logic [CNT_W-1:0]        len;
    logic                    in_valid;
    logic                    in_ready;
    logic [2*N-1:0]          product;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] acc_out;
    logic                    overflow;
    logic                    busy;

    modport slave (
        input  start, len, in_valid, product, out_ready,
        output in_ready, out_valid, acc_out, overflow, busy
    );

    modport master (
        output start, len, in_valid, product, out_ready,
        input  in_ready, out_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/signed_mac_accum.sv
// rtl/signed_mac_accum.sv - saturating signed accumulator over a programmed number of products
module signed_mac_accum #(
    parameter int N     = 32,
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    signed_mac_accum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam int EXT = ACC_W + 1 - 2 * N;
    localparam logic signed [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    generate
        if (ACC_W < 2 * N + 1) begin : g_acc_w_check
            $error("signed_mac_accum: ACC_W must be at least 2*N+1");
        end
    endgenerate

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
    logic signed [ACC_W:0]   sum;

    // One guard bit: the top two bits of sum disagree exactly when the true sum leaves the ACC_W range
    always_comb begin
        sum = {acc[ACC_W-1], acc} + {{EXT{bus.product[2*N-1]}}, bus.product};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        cnt <= bus.len;
                        state <= (bus.len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (sum[ACC_W] != sum[ACC_W-1]) begin
                            acc <= sum[ACC_W] ? NEG_MIN : POS_MAX;
                            ovf <= 1'b1;
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.acc_out   = acc;
    assign bus.overflow  = ovf;
endmodule

// File: tb/tb_signed_mac_accum.sv
// tb/tb_signed_mac_accum.sv - directed and random checks of signed_mac_accum at ACC_W=72 and ACC_W=65
module tb_signed_mac_accum;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    signed_mac_accum_if #(.N(32), .ACC_W(72), .CNT_W(8)) ia ();
    signed_mac_accum_if #(.N(32), .ACC_W(65), .CNT_W(8)) ib ();

    signed_mac_accum #(.N(32), .ACC_W(72), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    signed_mac_accum #(.N(32), .ACC_W(65), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    localparam logic [63:0] P_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] P_MIN = 64'h8000_0000_0000_0000;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ia.start = 0; ia.len = 0; ia.in_valid = 0; ia.product = 0; ia.out_ready = 0;
        ib.start = 0; ib.len = 0; ib.in_valid = 0; ib.product = 0; ib.out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b1;
        #2;
        total_cnt++; if (ia.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", ia.in_ready); else pass_cnt++;
        total_cnt++; if (ia.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", ia.out_valid); else pass_cnt++;
        total_cnt++; if (ia.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", ia.busy); else pass_cnt++;
        total_cnt++; if (ia.acc_out !== 72'd0) $display("FAIL reset_acc_out got %h exp 0", ia.acc_out); else pass_cnt++;
        total_cnt++; if (ia.overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", ia.overflow); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        ia.start = 1; ia.len = 3;
        cyc();
        ia.start = 0;
        total_cnt++; if (ia.in_ready !== 1'b1 || ia.busy !== 1'b1) $display("FAIL basic_accum_flags got in_ready=%b busy=%b exp 1 1", ia.in_ready, ia.busy); else pass_cnt++;
        ia.in_valid = 1; ia.product = 64'd6;
        cyc();
        ia.product = -64'd2;
        cyc();
        total_cnt++; if (ia.out_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", ia.out_valid); else pass_cnt++;
        ia.product = 64'd100;
        cyc();
        ia.in_valid = 0;
        total_cnt++; if (ia.out_valid !== 1'b1) $display("FAIL basic_out_valid got %b exp 1", ia.out_valid); else pass_cnt++;
        total_cnt++; if (ia.acc_out !== 72'd104) $display("FAIL basic_acc_out got %h exp %h", ia.acc_out, 72'd104); else pass_cnt++;
        total_cnt++; if (ia.overflow !== 1'b0) $display("FAIL basic_overflow got %b exp 0", ia.overflow); else pass_cnt++;
        total_cnt++; if (ia.in_ready !== 1'b0) $display("FAIL basic_done_in_ready got %b exp 0", ia.in_ready); else pass_cnt++;
        ia.out_ready = 1;
        cyc();
        ia.out_ready = 0;
        total_cnt++; if (ia.out_valid !== 1'b0 || ia.busy !== 1'b0) $display("FAIL basic_idle got out_valid=%b busy=%b exp 0 0", ia.out_valid, ia.busy); else pass_cnt++;
        total_cnt++; if (ia.acc_out !== 72'd104) $display("FAIL basic_hold got %h exp %h", ia.acc_out, 72'd104); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        ia.start = 1; ia.len = 2;
        cyc();
        ia.start = 0;
        ia.in_valid = 1; ia.product = P_MAX;
        cyc();
        ia.in_valid = 0; ia.product = 64'd12345;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total_cnt++; if (ia.in_ready !== 1'b1 || ia.out_valid !== 1'b0) $display("FAIL bubble_%0d got in_ready=%b out_valid=%b exp 1 0", i, ia.in_ready, ia.out_valid); else pass_cnt++;
        end
        ia.in_valid = 1; ia.product = 64'd1;
        cyc();
        ia.in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (ia.out_valid !== 1'b1 || ia.acc_out !== 72'h00_8000_0000_0000_0000) $display("FAIL backpressure_%0d got out_valid=%b acc=%h exp 1 008000000000000000", i, ia.out_valid, ia.acc_out); else pass_cnt++;
            cyc();
        end
        ia.out_ready = 1;
        cyc();
        ia.out_ready = 0;
        total_cnt++; if (ia.out_valid !== 1'b0 || ia.busy !== 1'b0) $display("FAIL backpressure_release got out_valid=%b busy=%b exp 0 0", ia.out_valid, ia.busy); else pass_cnt++;
    endtask

    task automatic test_saturation();
        ib.start = 1; ib.len = 3;
        cyc();
        ib.start = 0; ib.in_valid = 1; ib.product = P_MAX;
        cyc(); cyc(); cyc();
        ib.in_valid = 0;
        total_cnt++; if (ib.acc_out !== 65'h0_FFFF_FFFF_FFFF_FFFF) $display("FAIL sat_pos_acc got %h exp 0ffffffffffffffff", ib.acc_out); else pass_cnt++;
        total_cnt++; if (ib.overflow !== 1'b1) $display("FAIL sat_pos_overflow got %b exp 1", ib.overflow); else pass_cnt++;
        ib.out_ready = 1;
        cyc();
        ib.out_ready = 0;
        ib.start = 1; ib.len = 1;
        cyc();
        ib.start = 0; ib.in_valid = 1; ib.product = -64'd5;
        cyc();
        ib.in_valid = 0;
        total_cnt++; if (ib.acc_out !== 65'h1_FFFF_FFFF_FFFF_FFFB) $display("FAIL sat_next_acc got %h exp 1fffffffffffffffb", ib.acc_out); else pass_cnt++;
        total_cnt++; if (ib.overflow !== 1'b0) $display("FAIL sat_next_overflow got %b exp 0", ib.overflow); else pass_cnt++;
        ib.out_ready = 1;
        cyc();
        ib.out_ready = 0;
        // two minimum products land exactly on -2^64; the third must clamp there
        ib.start = 1; ib.len = 3;
        cyc();
        ib.start = 0; ib.in_valid = 1; ib.product = P_MIN;
        cyc(); cyc();
        total_cnt++; if (ib.acc_out !== 65'h1_0000_0000_0000_0000 || ib.overflow !== 1'b0) $display("FAIL sat_neg_edge got acc=%h ovf=%b exp 10000000000000000 0", ib.acc_out, ib.overflow); else pass_cnt++;
        cyc();
        ib.in_valid = 0;
        total_cnt++; if (ib.acc_out !== 65'h1_0000_0000_0000_0000 || ib.overflow !== 1'b1) $display("FAIL sat_neg got acc=%h ovf=%b exp 10000000000000000 1", ib.acc_out, ib.overflow); else pass_cnt++;
        ib.out_ready = 1;
        cyc();
        ib.out_ready = 0;
        ib.start = 1; ib.len = 4;
        cyc();
        ib.start = 0; ib.in_valid = 1; ib.product = P_MAX;
        cyc(); cyc(); cyc();
        ib.product = -64'd1;
        cyc();
        ib.in_valid = 0;
        total_cnt++; if (ib.acc_out !== 65'h0_FFFF_FFFF_FFFF_FFFE || ib.overflow !== 1'b1) $display("FAIL sat_continue got acc=%h ovf=%b exp 0fffffffffffffffe 1", ib.acc_out, ib.overflow); else pass_cnt++;
        ib.out_ready = 1;
        cyc();
        ib.out_ready = 0;
    endtask

    task automatic test_zero_len_and_ignored_start();
        ia.start = 1; ia.len = 0;
        cyc();
        ia.start = 0;
        total_cnt++; if (ia.out_valid !== 1'b1 || ia.acc_out !== 72'd0 || ia.busy !== 1'b1) $display("FAIL zero_len got out_valid=%b acc=%h busy=%b exp 1 0 1", ia.out_valid, ia.acc_out, ia.busy); else pass_cnt++;
        ia.out_ready = 1; ia.start = 1; ia.len = 5;
        cyc();
        ia.out_ready = 0; ia.start = 0;
        total_cnt++; if (ia.busy !== 1'b0 || ia.out_valid !== 1'b0) $display("FAIL zero_len_start_in_done got busy=%b out_valid=%b exp 0 0", ia.busy, ia.out_valid); else pass_cnt++;
        ia.start = 1; ia.len = 2;
        cyc();
        ia.start = 0; ia.in_valid = 1; ia.product = 64'd10;
        cyc();
        ia.start = 1; ia.len = 9; ia.product = 64'd20;
        cyc();
        ia.start = 0; ia.in_valid = 0;
        total_cnt++; if (ia.out_valid !== 1'b1 || ia.acc_out !== 72'd30) $display("FAIL start_in_accum got out_valid=%b acc=%h exp 1 %h", ia.out_valid, ia.acc_out, 72'd30); else pass_cnt++;
        ia.out_ready = 1; ia.start = 1; ia.len = 1;
        cyc();
        ia.out_ready = 0; ia.start = 0;
        total_cnt++; if (ia.busy !== 1'b0 || ia.in_ready !== 1'b0 || ia.acc_out !== 72'd30) $display("FAIL start_with_out_ready got busy=%b in_ready=%b acc=%h exp 0 0 %h", ia.busy, ia.in_ready, ia.acc_out, 72'd30); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        ia.start = 1; ia.len = 4;
        cyc();
        ia.start = 0; ia.in_valid = 1; ia.product = 64'd3;
        cyc();
        ia.product = 64'd4;
        cyc();
        ia.in_valid = 0;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (ia.in_ready !== 1'b0 || ia.busy !== 1'b0 || ia.acc_out !== 72'd0 || ia.out_valid !== 1'b0) $display("FAIL async_reset got in_ready=%b busy=%b acc=%h out_valid=%b exp 0 0 0 0", ia.in_ready, ia.busy, ia.acc_out, ia.out_valid); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        ia.start = 1; ia.len = 1;
        cyc();
        ia.start = 0; ia.in_valid = 1; ia.product = 64'd7;
        cyc();
        ia.in_valid = 0;
        total_cnt++; if (ia.out_valid !== 1'b1 || ia.acc_out !== 72'd7) $display("FAIL after_reset got out_valid=%b acc=%h exp 1 %h", ia.out_valid, ia.acc_out, 72'd7); else pass_cnt++;
        ia.out_ready = 1;
        cyc();
        ia.out_ready = 0;
    endtask

    task automatic test_random();
        localparam logic signed [65:0] MAXV = (66'sd1 <<< 64) - 66'sd1;
        localparam logic signed [65:0] MINV = -(66'sd1 <<< 64);
        logic signed [65:0] model;
        logic signed [65:0] s;
        logic               movf;
        logic [63:0]        p;
        int                 len;
        for (int job = 0; job < 50; job++) begin
            len = $urandom_range(1, 20);
            model = 0; movf = 0;
            ib.start = 1; ib.len = 8'(len);
            cyc();
            ib.start = 0;
            for (int t = 0; t < len; t++) begin
                repeat ($urandom_range(0, 2)) cyc();
                case ($urandom_range(0, 3))
                    0: p = P_MAX - 64'($urandom_range(0, 7));
                    1: p = P_MIN + 64'($urandom_range(0, 7));
                    default: p = {$urandom(), $urandom()};
                endcase
                s = model + $signed({{2{p[63]}}, p});
                if (s > MAXV) begin model = MAXV; movf = 1; end
                else if (s < MINV) begin model = MINV; movf = 1; end
                else model = s;
                ib.in_valid = 1; ib.product = p;
                cyc();
                ib.in_valid = 0;
            end
            repeat ($urandom_range(0, 3)) cyc();
            total_cnt++; if (ib.out_valid !== 1'b1) $display("FAIL rand_%0d_valid got %b exp 1", job, ib.out_valid); else pass_cnt++;
            total_cnt++; if (ib.acc_out !== model[64:0]) $display("FAIL rand_%0d_acc got %h exp %h", job, ib.acc_out, model[64:0]); else pass_cnt++;
            total_cnt++; if (ib.overflow !== movf) $display("FAIL rand_%0d_overflow got %b exp %b", job, ib.overflow, movf); else pass_cnt++;
            ib.out_ready = 1;
            cyc();
            ib.out_ready = 0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_zero_len_and_ignored_start();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
